// File: rtl/stage5_writeback_pkg.sv
// Shared types and constants for the writeback stage: decoded-instruction layout,
// memory->writeback beat payload, load/CSR funct3 codes and counter CSR addresses.
package stage5_writeback_pkg;

  localparam int unsigned REGISTER_WIDTH = 32;
  localparam int unsigned COUNTER_WIDTH  = 64;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] CSRRS  = 3'b010;

  typedef enum logic [11:0] {
    CSR_CYCLE    = 12'hC00,
    CSR_TIME     = 12'hC01,
    CSR_INSTRET  = 12'hC02,
    CSR_CYCLEH   = 12'hC80,
    CSR_TIMEH    = 12'hC81,
    CSR_INSTRETH = 12'hC82
  } csr_address_e;

  typedef struct packed {
    logic [31:0] i_type;
  } immediate_t;

  typedef struct packed {
    opcode_e    opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    immediate_t immediate;
  } decoded_instruction_t;

  typedef struct packed {
    decoded_instruction_t              decoded_instruction;
    logic [REGISTER_WIDTH-1:0]         alu_result;
    logic [REGISTER_WIDTH-1:0]         data_from_memory;
    logic [REGISTER_WIDTH-1:0]         branch_target;
  } mem_wb_tdata_t;

endpackage

// File: rtl/stage5_writeback_if.sv
// AXI-stream style memory->writeback beat channel.
interface stage5_writeback_if;
  import stage5_writeback_pkg::*;

  mem_wb_tdata_t tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/stage5_writeback_load_extend.sv
// Load lane selection and sign/zero extension, plus misalignment detection.
module stage5_writeback_load_extend
  import stage5_writeback_pkg::*;
(
  input  logic [2:0]                funct3,
  input  logic [1:0]                addr,
  input  logic [REGISTER_WIDTH-1:0] word,
  output logic [REGISTER_WIDTH-1:0] value,
  output logic                      misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    value      = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  value = {{(REGISTER_WIDTH-8){byte_lane[7]}}, byte_lane};
      F3_LBU: value = {{(REGISTER_WIDTH-8){1'b0}}, byte_lane};
      F3_LH: begin
        value      = {{(REGISTER_WIDTH-16){half_lane[15]}}, half_lane};
        misaligned = addr[0];
      end
      F3_LHU: begin
        value      = {{(REGISTER_WIDTH-16){1'b0}}, half_lane};
        misaligned = addr[0];
      end
      F3_LW:  misaligned = (addr != 2'b00);
      default: ;
    endcase
  end

endmodule

// File: rtl/stage5_writeback.sv
// Final pipeline stage: selects the writeback value, retires instructions and owns
// the cycle/instret counters that back the rdcycle/rdinstret CSR reads.
module stage5_writeback
  import stage5_writeback_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  stage5_writeback_if.slave         axis_memory_to_writeback,
  output logic                      regfile_write_enable,
  output logic [4:0]                regfile_write_address,
  output logic [REGISTER_WIDTH-1:0] regfile_write_data,
  output logic                      retired,
  output logic                      load_misaligned,
  output logic [COUNTER_WIDTH-1:0]  cycle_count,
  output logic [COUNTER_WIDTH-1:0]  instret_count
);

  logic                      accept;
  opcode_e                   opcode;
  logic [2:0]                funct3;
  logic [4:0]                rd;
  logic [4:0]                rs1;
  logic [11:0]               csr_addr;
  logic [REGISTER_WIDTH-1:0] alu_result;
  logic [REGISTER_WIDTH-1:0] mem_word;
  logic [REGISTER_WIDTH-1:0] load_value;
  logic                      load_bad;
  logic [REGISTER_WIDTH-1:0] csr_value;
  logic [REGISTER_WIDTH-1:0] result;
  logic                      writes;
  logic                      retire;
  logic                      misalign;

  assign axis_memory_to_writeback.tready = !rst;
  assign accept     = axis_memory_to_writeback.tvalid && !rst;
  assign opcode     = axis_memory_to_writeback.tdata.decoded_instruction.opcode;
  assign funct3     = axis_memory_to_writeback.tdata.decoded_instruction.funct3;
  assign rd         = axis_memory_to_writeback.tdata.decoded_instruction.rd;
  assign rs1        = axis_memory_to_writeback.tdata.decoded_instruction.rs1;
  assign csr_addr   = axis_memory_to_writeback.tdata.decoded_instruction.immediate.i_type[11:0];
  assign alu_result = axis_memory_to_writeback.tdata.alu_result;
  assign mem_word   = axis_memory_to_writeback.tdata.data_from_memory;

  stage5_writeback_load_extend u_load_extend (
    .funct3     (funct3),
    .addr       (alu_result[1:0]),
    .word       (mem_word),
    .value      (load_value),
    .misaligned (load_bad)
  );

  // CSR reads see the counters as registered before the accepting edge.
  always_comb begin
    csr_value = '0;
    case (csr_addr)
      CSR_CYCLE, CSR_TIME:   csr_value = cycle_count[REGISTER_WIDTH-1:0];
      CSR_CYCLEH, CSR_TIMEH: csr_value = cycle_count[COUNTER_WIDTH-1:REGISTER_WIDTH];
      CSR_INSTRET:           csr_value = instret_count[REGISTER_WIDTH-1:0];
      CSR_INSTRETH:          csr_value = instret_count[COUNTER_WIDTH-1:REGISTER_WIDTH];
      default:               csr_value = '0;
    endcase
  end

  always_comb begin
    result   = alu_result;
    writes   = 1'b0;
    retire   = 1'b0;
    misalign = 1'b0;
    if (accept) begin
      writes = 1'b1;
      retire = 1'b1;
      case (opcode)
        OP_LOAD: begin
          result = load_value;
          if (load_bad) begin
            writes   = 1'b0;
            retire   = 1'b0;
            misalign = 1'b1;
          end
        end
        OP_STORE, OP_BRANCH: writes = 1'b0;
        OP_SYSTEM: begin
          if (funct3 == CSRRS && rs1 == 5'd0) result = csr_value;
          else                                writes = 1'b0;
        end
        default: ;
      endcase
      if (rd == 5'd0) writes = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regfile_write_enable  <= 1'b0;
      regfile_write_address <= '0;
      regfile_write_data    <= '0;
      retired               <= 1'b0;
      load_misaligned       <= 1'b0;
      cycle_count           <= '0;
      instret_count         <= '0;
    end else begin
      regfile_write_enable  <= writes;
      regfile_write_address <= rd;
      regfile_write_data    <= result;
      retired               <= retire;
      load_misaligned       <= misalign;
      cycle_count           <= cycle_count + COUNTER_WIDTH'(1);
      instret_count         <= instret_count + COUNTER_WIDTH'(retire);
    end
  end

endmodule

// File: doc/stage5_writeback.md
# stage5_writeback

Final pipeline stage: consumes the memory→writeback AXI-stream beat and drives the register-file write port. Load data is aligned and extended here, and the hardware cycle/instret counters live here. The stage also retires every instruction and resolves counter CSR reads (rdcycle/rdinstret and their high halves), because the counters are owned by this stage.

## Interface
Parameters
- REGISTER_WIDTH, package constant (32): data-path width.
- COUNTER_WIDTH, 64: width of the cycle and instret counters.

Ports
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- axis_memory_to_writeback  Axis.in  beat  tdata fields: decoded_instruction, alu_result, data_from_memory, branch_target; tvalid in, tready out.
- regfile_write_enable  out  1  register-file write strobe.
- regfile_write_address  out  5  destination register index.
- regfile_write_data  out  REGISTER_WIDTH  value written.
- retired  out  1  one-cycle pulse per retired instruction.
- load_misaligned  out  1  one-cycle pulse on a misaligned load.
- cycle_count  out  COUNTER_WIDTH  free-running cycle counter.
- instret_count  out  COUNTER_WIDTH  retired-instruction counter.

## Operation
- **Acceptance.** tready = !rst; the stage never stalls. A beat is accepted when tvalid && tready.
- **Result select** by decoded_instruction.opcode:
  - OP_LOAD: extended load data.
  - OP_STORE, OP_BRANCH: no register write.
  - OP_SYSTEM with funct3 = CSRRS and rs1 = x0: counter read, selected by immediate.i_type[11:0]:
    - 0xC00 → cycle[31:0]; 0xC80 → cycle[63:32].
    - 0xC01 → cycle[31:0] (time aliases cycle); 0xC81 → cycle[63:32].
    - 0xC02 → instret[31:0]; 0xC82 → instret[63:32].
    - Any other CSR address → 0.
  - Any other SYSTEM instruction: no write, but it still retires.
  - All other opcodes: alu_result. Execute places the link address in alu_result for JAL/JALR.
- **Load extension.** alu_result holds the effective address; data_from_memory is the aligned 32-bit word.
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended.
  - LH/LHU: half lane addr[1], sign- or zero-extended.
  - LW: whole word.
- **Misaligned loads.** LH/LHU with addr[0]=1, or LW with addr[1:0]≠0:
  - No write and no retire.
  - load_misaligned pulses.
- **x0 destination.** rd = x0 forces regfile_write_enable = 0; the instruction still retires.
- **Counters.**
  - cycle increments every cycle with rst=0.
  - instret increments in the cycle retired is high.
  - Both wrap modulo 2^64.

## Timing
- **Reset values.** During rst, all outputs are 0 the following cycle:
  - regfile_write_enable, regfile_write_address, regfile_write_data;
  - retired, load_misaligned;
  - cycle_count, instret_count.
- **Reset mid-operation.** A beat presented during a reset cycle is dropped.
- **Latency.** A beat accepted at edge N drives the write port, retired and load_misaligned during cycle N+1 for exactly one cycle. All of these outputs are registered.
- **Back-to-back.** Beats on consecutive cycles produce writes on consecutive cycles. There are no bubbles and no hazards inside the stage.
- **CSR read values.**
  - A CSR read returns the counter value registered at acceptance edge N.
  - instret therefore excludes the reading instruction itself.
  - cycle equals the number of non-reset cycles before edge N.
- **Simultaneous events.** A retirement in the same cycle as a 2^64−1 instret value wraps instret to 0; cycle counts on independently.
- **Idle cycles.** When tvalid=0, all pulse outputs are 0 and regfile_write_enable is 0.

## Structure
- **Shared package additions:**
  - csr_address_e enum: CSR_CYCLE, CSR_TIME, CSR_INSTRET, and the *H variants.
  - Funct3 constant CSRRS.
  - COUNTER_WIDTH.
  - The memory→writeback tdata struct stays in the package.
- **Sub-module load_extend (combinational):**
  - Inputs: funct3, addr[1:0], word.
  - Outputs: extended value and misaligned flag.
- The counters and output registers stay in stage5_writeback.

## Test plan
- **LB sign extension.** LB, addr=0x1003, word=0x80FF_1234, rd=x5 → cycle N+1: write x5 = 0xFFFF_FF80, retired=1.
- **LHU and x0 destination.**
  - LHU, addr=0x2002, word=0x8001_7777, rd=x6 → write 0x0000_8001.
  - Same beat with rd=x0 → write_enable=0, retired=1.
- **Misaligned LW.** LW, addr=0x3001 → no write, retired=0, load_misaligned=1 for one cycle; instret unchanged.
- **CSR counter reads.** Reset, then 10 idle cycles, then rdinstret (CSRRS 0xC02, rs1=x0, rd=x7) → x7 = 0. A following rdcycle → value equals the cycles elapsed since reset release.
- **Back-to-back and mid-stream reset.**
  - 4 consecutive ADD beats (alu_result 1..4) → writes 1,2,3,4 on consecutive cycles; instret = 4.
  - Assert rst in the middle of the stream → all outputs 0 next cycle; the in-flight beat is dropped.
